// File: rtl/rf_alu_pipe.sv
// Two-stage register-file + ALU pipeline: ISSUE reads and forwards operands,
// EX computes, writes back and publishes the result through a valid/ready port.
module rf_alu_pipe #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned NREGS = 8,
   localparam int unsigned AW = $clog2(NREGS),
   localparam int unsigned HW = WIDTH / 2
) (
   input  logic             CLK,
   input  logic             CLR,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic             set_flags,
   input  logic [AW-1:0]    rd,
   input  logic [AW-1:0]    rm,
   input  logic [AW-1:0]    rn,
   input  logic             use_imm,
   input  logic [HW-1:0]    imm,
   input  logic             ext_wr_en,
   input  logic [AW-1:0]    ext_wr_addr,
   input  logic [WIDTH-1:0] ext_wr_data,
   output logic [WIDTH-1:0] res,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             N,
   output logic             Z,
   output logic             C,
   output logic             V
);

   localparam int unsigned SW = $clog2(WIDTH);

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_ADC = 4'd1;
   localparam logic [3:0] OP_SUB = 4'd2;
   localparam logic [3:0] OP_SBC = 4'd3;
   localparam logic [3:0] OP_AND = 4'd4;
   localparam logic [3:0] OP_OR  = 4'd5;
   localparam logic [3:0] OP_XOR = 4'd6;
   localparam logic [3:0] OP_NOT = 4'd7;
   localparam logic [3:0] OP_SHL = 4'd8;
   localparam logic [3:0] OP_SHR = 4'd9;
   localparam logic [3:0] OP_MOV = 4'd10;
   localparam logic [3:0] OP_LHI = 4'd11;
   localparam logic [3:0] OP_LLI = 4'd12;
   localparam logic [3:0] OP_CMP = 4'd13;

   logic [WIDTH-1:0] rf [NREGS];

   logic             ex_valid;
   logic [3:0]       ex_op;
   logic [AW-1:0]    ex_rd;
   logic             ex_sf;
   logic [WIDTH-1:0] ex_a;
   logic [WIDTH-1:0] ex_b;
   logic [HW-1:0]    ex_imm;

   logic             ex_fire;
   logic             ex_wr;
   logic             accept;

   logic [AW-1:0]    b_addr;
   logic [WIDTH-1:0] a_fwd;
   logic [WIDTH-1:0] b_fwd;
   logic [WIDTH-1:0] opnd_b;

   logic [WIDTH-1:0] b_arith;
   logic             cin;
   logic [WIDTH:0]   sum;
   logic [SW-1:0]    shamt;
   logic [WIDTH-1:0] alu_res;
   logic             alu_c;
   logic             alu_v;
   logic             is_arith;
   logic             is_logic;

   // Handshake: EX drains when the result slot is free or being consumed
   assign ex_fire  = ex_valid & (~res_valid | res_ready);
   assign in_ready = ~ex_valid | ex_fire;
   assign accept   = in_valid & in_ready;
   assign ex_wr    = ex_fire & (ex_op <= OP_LLI);

   // Operand read with forwarding: EX writeback first, then the external port, then RF
   always_comb begin
      b_addr = (op == OP_LHI) ? rd : rn;
      a_fwd  = rf[rm];
      b_fwd  = rf[b_addr];
      if (ex_wr && (rm == ex_rd))
         a_fwd = alu_res;
      else if (ext_wr_en && (rm == ext_wr_addr))
         a_fwd = ext_wr_data;
      if (ex_wr && (b_addr == ex_rd))
         b_fwd = alu_res;
      else if (ext_wr_en && (b_addr == ext_wr_addr))
         b_fwd = ext_wr_data;
      opnd_b = (use_imm && (op != OP_LHI)) ? {HW'(0), imm} : b_fwd;
   end

   // EX-stage ALU; subtraction is A + ~B + carry-in so one adder serves all arithmetic
   always_comb begin
      b_arith = ex_b;
      cin     = 1'b0;
      case (ex_op)
         OP_ADC:         cin = C;
         OP_SUB, OP_CMP: begin b_arith = ~ex_b; cin = 1'b1; end
         OP_SBC:         begin b_arith = ~ex_b; cin = C;    end
         default:        cin = 1'b0;
      endcase
      sum   = {1'b0, ex_a} + {1'b0, b_arith} + {{WIDTH{1'b0}}, cin};
      alu_c = sum[WIDTH];
      alu_v = (ex_a[WIDTH-1] == b_arith[WIDTH-1]) && (sum[WIDTH-1] != ex_a[WIDTH-1]);
      shamt = ex_b[SW-1:0];
      case (ex_op)
         OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_CMP: alu_res = sum[WIDTH-1:0];
         OP_AND:  alu_res = ex_a & ex_b;
         OP_OR:   alu_res = ex_a | ex_b;
         OP_XOR:  alu_res = ex_a ^ ex_b;
         OP_NOT:  alu_res = ~ex_a;
         OP_SHL:  alu_res = ex_a << shamt;
         OP_SHR:  alu_res = ex_a >> shamt;
         OP_MOV:  alu_res = ex_a;
         OP_LHI:  alu_res = {ex_imm, ex_b[HW-1:0]};
         OP_LLI:  alu_res = {HW'(0), ex_imm};
         default: alu_res = '0;
      endcase
      is_arith = (ex_op <= OP_SBC) || (ex_op == OP_CMP);
      is_logic = (ex_op >= OP_AND) && (ex_op <= OP_SHR);
   end

   // Register file: external write first so a same-edge EX writeback overrides it
   always_ff @(posedge CLK) begin
      if (CLR) begin
         for (int unsigned i = 0; i < NREGS; i++)
            rf[AW'(i)] <= '0;
      end else begin
         if (ext_wr_en)
            rf[ext_wr_addr] <= ext_wr_data;
         if (ex_wr)
            rf[ex_rd] <= alu_res;
      end
   end

   // EX pipeline register: loads on accept, empties on fire, holds while stalled
   always_ff @(posedge CLK) begin
      if (CLR) begin
         ex_valid <= 1'b0;
         ex_op    <= '0;
         ex_rd    <= '0;
         ex_sf    <= 1'b0;
         ex_a     <= '0;
         ex_b     <= '0;
         ex_imm   <= '0;
      end else if (accept) begin
         ex_valid <= 1'b1;
         ex_op    <= op;
         ex_rd    <= rd;
         ex_sf    <= set_flags;
         ex_a     <= a_fwd;
         ex_b     <= opnd_b;
         ex_imm   <= imm;
      end else if (ex_fire) begin
         ex_valid <= 1'b0;
      end
   end

   // Result slot and condition flags, updated when EX completes
   always_ff @(posedge CLK) begin
      if (CLR) begin
         res       <= '0;
         res_valid <= 1'b0;
         N         <= 1'b0;
         Z         <= 1'b0;
         C         <= 1'b0;
         V         <= 1'b0;
      end else begin
         if (ex_fire) begin
            res       <= alu_res;
            res_valid <= 1'b1;
            if (is_arith && (ex_sf || (ex_op == OP_CMP))) begin
               N <= alu_res[WIDTH-1];
               Z <= (alu_res == '0);
               C <= alu_c;
               V <= alu_v;
            end else if (is_logic && ex_sf) begin
               N <= alu_res[WIDTH-1];
               Z <= (alu_res == '0);
            end
         end else if (res_ready) begin
            res_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rf_alu_pipe.sv
// Directed self-checking bench for rf_alu_pipe (WIDTH=16, NREGS=8).
module tb_rf_alu_pipe;

   localparam int unsigned WIDTH = 16;
   localparam int unsigned NREGS = 8;
   localparam int unsigned AW    = 3;
   localparam int unsigned HW    = 8;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_ADC = 4'd1;
   localparam logic [3:0] OP_SUB = 4'd2;
   localparam logic [3:0] OP_SBC = 4'd3;
   localparam logic [3:0] OP_AND = 4'd4;
   localparam logic [3:0] OP_NOT = 4'd7;
   localparam logic [3:0] OP_SHL = 4'd8;
   localparam logic [3:0] OP_SHR = 4'd9;
   localparam logic [3:0] OP_MOV = 4'd10;
   localparam logic [3:0] OP_LHI = 4'd11;
   localparam logic [3:0] OP_LLI = 4'd12;
   localparam logic [3:0] OP_CMP = 4'd13;
   localparam logic [3:0] OP_NOP = 4'd14;

   logic             CLK;
   logic             CLR;
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       op;
   logic             set_flags;
   logic [AW-1:0]    rd;
   logic [AW-1:0]    rm;
   logic [AW-1:0]    rn;
   logic             use_imm;
   logic [HW-1:0]    imm;
   logic             ext_wr_en;
   logic [AW-1:0]    ext_wr_addr;
   logic [WIDTH-1:0] ext_wr_data;
   logic [WIDTH-1:0] res;
   logic             res_valid;
   logic             res_ready;
   logic             N, Z, C, V;

   int n_checks = 0;
   int n_fail   = 0;

   rf_alu_pipe #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
      .CLK(CLK), .CLR(CLR),
      .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .set_flags(set_flags),
      .rd(rd), .rm(rm), .rn(rn),
      .use_imm(use_imm), .imm(imm),
      .ext_wr_en(ext_wr_en), .ext_wr_addr(ext_wr_addr), .ext_wr_data(ext_wr_data),
      .res(res), .res_valid(res_valid), .res_ready(res_ready),
      .N(N), .Z(Z), .C(C), .V(V)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic set_instr(input logic [3:0] t_op, input logic [2:0] t_rd, input logic [2:0] t_rm,
                            input logic [2:0] t_rn, input logic t_ui, input logic [7:0] t_imm,
                            input logic t_sf);
      op = t_op; rd = t_rd; rm = t_rm; rn = t_rn;
      use_imm = t_ui; imm = t_imm; set_flags = t_sf;
      in_valid = 1'b1;
   endtask

   // Offer one instruction and return #1 after the edge that accepts it
   task automatic send(input logic [3:0] t_op, input logic [2:0] t_rd, input logic [2:0] t_rm,
                       input logic [2:0] t_rn, input logic t_ui, input logic [7:0] t_imm,
                       input logic t_sf);
      int guard = 0;
      set_instr(t_op, t_rd, t_rm, t_rn, t_ui, t_imm, t_sf);
      while (!in_ready && guard < 20) begin
         @(posedge CLK); #1;
         guard++;
      end
      if (guard >= 20) check("send_timeout", 32'd0, 32'd1);
      @(posedge CLK); #1;
      in_valid = 1'b0;
   endtask

   // Read a register by issuing MOV rx,rx and sampling the result after it completes
   task automatic chk_reg(input string tag, input logic [2:0] a, input logic [15:0] exp);
      send(OP_MOV, a, a, 3'd0, 1'b0, 8'd0, 1'b0);
      @(posedge CLK); #1;
      check(tag, {res_valid, res}, {1'b1, exp});
   endtask

   task automatic chk_flags(input string tag, input logic [3:0] exp);
      check(tag, {28'd0, N, Z, C, V}, {28'd0, exp});
   endtask

   initial begin
      CLR = 1'b1; in_valid = 1'b0; op = '0; set_flags = 1'b0;
      rd = '0; rm = '0; rn = '0; use_imm = 1'b0; imm = '0;
      ext_wr_en = 1'b0; ext_wr_addr = '0; ext_wr_data = '0; res_ready = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      CLR = 1'b0;
      check("reset_res", res, 16'h0000);
      check("reset_res_valid", res_valid, 1'b0);
      chk_flags("reset_flags", 4'b0000);
      check("reset_in_ready", in_ready, 1'b1);

      // LLI/LHI back-to-back, LHI takes forwarded low byte
      send(OP_LLI, 3'd1, 3'd0, 3'd0, 1'b0, 8'h34, 1'b0);
      send(OP_LHI, 3'd1, 3'd0, 3'd0, 1'b0, 8'h12, 1'b0);
      chk_reg("lli_lhi_r1", 3'd1, 16'h1234);

      // 0xFFFF + 1 with flags, then ADC using the carry
      send(OP_LLI, 3'd2, 3'd0, 3'd0, 1'b0, 8'hFF, 1'b0);
      send(OP_LHI, 3'd2, 3'd0, 3'd0, 1'b0, 8'hFF, 1'b0);
      send(OP_LLI, 3'd3, 3'd0, 3'd0, 1'b0, 8'h01, 1'b0);
      send(OP_ADD, 3'd4, 3'd2, 3'd3, 1'b0, 8'h00, 1'b1);
      chk_reg("add_wrap_r4", 3'd4, 16'h0000);
      chk_flags("add_wrap_flags", 4'b0110);
      send(OP_ADC, 3'd5, 3'd3, 3'd3, 1'b0, 8'h00, 1'b0);
      chk_reg("adc_r5", 3'd5, 16'h0003);

      // Signed overflow, logical flag update holding C/V, CMP without write
      send(OP_LLI, 3'd2, 3'd0, 3'd0, 1'b0, 8'hFF, 1'b0);
      send(OP_LHI, 3'd2, 3'd0, 3'd0, 1'b0, 8'h7F, 1'b0);
      send(OP_ADD, 3'd4, 3'd2, 3'd0, 1'b1, 8'h01, 1'b1);
      chk_reg("add_ovf_r4", 3'd4, 16'h8000);
      chk_flags("add_ovf_flags", 4'b1001);
      send(OP_AND, 3'd6, 3'd3, 3'd0, 1'b1, 8'h02, 1'b1);
      chk_reg("and_imm_r6", 3'd6, 16'h0000);
      chk_flags("and_keeps_cv", 4'b0101);
      send(OP_CMP, 3'd4, 3'd2, 3'd2, 1'b0, 8'h00, 1'b0);
      chk_reg("cmp_no_write_r4", 3'd4, 16'h8000);
      chk_flags("cmp_flags", 4'b0110);

      // SUB borrow, NOP, SBC with C=0
      send(OP_SUB, 3'd5, 3'd3, 3'd2, 1'b0, 8'h00, 1'b1);
      chk_reg("sub_r5", 3'd5, 16'h8002);
      chk_flags("sub_flags", 4'b1000);
      send(OP_NOP, 3'd5, 3'd3, 3'd3, 1'b0, 8'h00, 1'b1);
      @(posedge CLK); #1;
      check("nop_res", {res_valid, res}, {1'b1, 16'h0000});
      chk_flags("nop_flags", 4'b1000);
      send(OP_SBC, 3'd5, 3'd3, 3'd3, 1'b0, 8'h00, 1'b0);
      chk_reg("sbc_r5", 3'd5, 16'hFFFF);

      // Shifts (upper shift bits ignored), NOT, AND with flags
      send(OP_SHL, 3'd6, 3'd3, 3'd0, 1'b1, 8'h04, 1'b0);
      chk_reg("shl_r6", 3'd6, 16'h0010);
      send(OP_SHR, 3'd6, 3'd2, 3'd0, 1'b1, 8'h13, 1'b0);
      chk_reg("shr_r6", 3'd6, 16'h0FFF);
      send(OP_NOT, 3'd6, 3'd3, 3'd0, 1'b0, 8'h00, 1'b0);
      chk_reg("not_r6", 3'd6, 16'hFFFE);
      send(OP_AND, 3'd6, 3'd2, 3'd5, 1'b0, 8'h00, 1'b1);
      chk_reg("and_r6", 3'd6, 16'h7FFF);
      chk_flags("and_flags", 4'b0000);

      // Flag chain: ADD sets C, ADC right behind it consumes it
      send(OP_ADD, 3'd4, 3'd5, 3'd3, 1'b0, 8'h00, 1'b1);
      send(OP_ADC, 3'd1, 3'd3, 3'd3, 1'b0, 8'h00, 1'b0);
      chk_reg("chain_adc_r1", 3'd1, 16'h0003);
      chk_flags("chain_flags", 4'b0110);

      // Backpressure: three LLI r1 with res_ready low
      res_ready = 1'b1;
      @(posedge CLK); #1;
      res_ready = 1'b0;
      set_instr(OP_LLI, 3'd1, 3'd0, 3'd0, 1'b0, 8'h11, 1'b0);
      @(posedge CLK); #1;
      set_instr(OP_LLI, 3'd1, 3'd0, 3'd0, 1'b0, 8'h22, 1'b0);
      @(posedge CLK); #1;
      check("stall_first_res", {res_valid, res}, {1'b1, 16'h0011});
      set_instr(OP_LLI, 3'd1, 3'd0, 3'd0, 1'b0, 8'h33, 1'b0);
      check("stall_in_ready_low", in_ready, 1'b0);
      @(posedge CLK); #1;
      check("stall_hold_in_ready", in_ready, 1'b0);
      check("stall_hold_res", res, 16'h0011);
      check("stall_rf_unchanged", dut.rf[1], 16'h0011);
      res_ready = 1'b1;
      @(posedge CLK); #1;
      in_valid = 1'b0;
      check("stall_second_res", {res_valid, res}, {1'b1, 16'h0022});
      @(posedge CLK); #1;
      check("stall_third_res", {res_valid, res}, {1'b1, 16'h0033});
      check("stall_rf_final", dut.rf[1], 16'h0033);

      // External write port: conflict, separate addresses, forwarding
      send(OP_LLI, 3'd5, 3'd0, 3'd0, 1'b0, 8'h55, 1'b0);
      send(OP_LHI, 3'd5, 3'd0, 3'd0, 1'b0, 8'h55, 1'b0);
      send(OP_MOV, 3'd6, 3'd5, 3'd0, 1'b0, 8'h00, 1'b0);
      ext_wr_en = 1'b1; ext_wr_addr = 3'd6; ext_wr_data = 16'hAAAA;
      @(posedge CLK); #1;
      ext_wr_en = 1'b0;
      chk_reg("ext_conflict_r6", 3'd6, 16'h5555);
      send(OP_LLI, 3'd6, 3'd0, 3'd0, 1'b0, 8'h77, 1'b0);
      ext_wr_en = 1'b1; ext_wr_addr = 3'd7; ext_wr_data = 16'hAAAA;
      @(posedge CLK); #1;
      ext_wr_en = 1'b0;
      chk_reg("ext_both_r6", 3'd6, 16'h0077);
      chk_reg("ext_both_r7", 3'd7, 16'hAAAA);
      ext_wr_en = 1'b1; ext_wr_addr = 3'd0; ext_wr_data = 16'h1357;
      send(OP_MOV, 3'd3, 3'd0, 3'd0, 1'b0, 8'h00, 1'b0);
      ext_wr_en = 1'b0;
      chk_reg("ext_fwd_r3", 3'd3, 16'h1357);

      // CLR while EX holds ADD r7; concurrent ext write is dropped
      send(OP_ADD, 3'd7, 3'd5, 3'd5, 1'b0, 8'h00, 1'b1);
      CLR = 1'b1;
      ext_wr_en = 1'b1; ext_wr_addr = 3'd0; ext_wr_data = 16'hFFFF;
      @(posedge CLK); #1;
      CLR = 1'b0;
      ext_wr_en = 1'b0;
      check("clr_res_valid", res_valid, 1'b0);
      check("clr_res", res, 16'h0000);
      chk_flags("clr_flags", 4'b0000);
      check("clr_in_ready", in_ready, 1'b1);
      chk_reg("clr_r7", 3'd7, 16'h0000);
      chk_reg("clr_r0", 3'd0, 16'h0000);
      chk_reg("clr_r5", 3'd5, 16'h0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rf_alu_pipe.md
RF_ALU_PIPE -- requirements
Module: rf_alu_pipe

Interface
REQ-001 Parameter WIDTH, default 16, datapath and register width; even, at least 8.
REQ-002 Parameter NREGS, default 8, register count; power of 2; AW = log2(NREGS).
REQ-003 One clock; reset is synchronous and active-high; CLK  in  1  clock, all state on rising edge.
REQ-004 CLR  in  1  synchronous active-high reset.
REQ-005 in_valid  in  1  instruction offered; in_ready  out  1  instruction accepted when in_valid & in_ready.
REQ-006 op  in  4  operation code (REQ-014); set_flags  in  1  update flags for this instruction.
REQ-007 rd, rm, rn  in  AW each  destination, source A, source B addresses.
REQ-008 use_imm  in  1  operand B = zero-extended imm; imm  in  WIDTH/2  immediate.
REQ-009 ext_wr_en  in  1, ext_wr_addr  in  AW, ext_wr_data  in  WIDTH  external (memory/PC) write port.
REQ-010 res  out  WIDTH  last completed result; res_valid  out  1; res_ready  in  1  consumer accepts res.
REQ-011 N, Z, C, V  out  1 each  registered flags.

Function
REQ-012 Two stages: ISSUE (operand read, accepted into EX register) and EX (ALU, writeback); accept at edge k, RF/flags/res update at edge k+1 earliest; res_valid high from cycle after.
REQ-013 ex_fire = ex_valid & (!res_valid | res_ready); in_ready = !ex_valid | ex_fire; EX holds contents unchanged while stalled.
REQ-014 Ops: 0 ADD, 1 ADC, 2 SUB, 3 SBC, 4 AND, 5 OR, 6 XOR, 7 NOT A, 8 SHL, 9 SHR (logical), 10 MOV A, 11 LHI, 12 LLI, 13 CMP, 14-15 NOP.
REQ-015 A = R[rm]; B = use_imm ? zero-ext imm : R[rn]; for LHI, B port reads R[rd].
REQ-016 ADD A+B; ADC A+B+C; SUB A+~B+1; SBC A+~B+C; all modulo 2^WIDTH.
REQ-017 SHL/SHR shift by B[log2(WIDTH)-1:0]; upper bits of B ignored.
REQ-018 LHI = {imm, R[rd][WIDTH/2-1:0]}; LLI = {zeros, imm}.
REQ-019 CMP computes SUB, writes no register, always updates all four flags regardless of set_flags.
REQ-020 NOP: no register write, no flag change, still produces res_valid with res = 0.
REQ-021 All other ops write result to R[rd] at ex_fire.
REQ-022 When set_flags: arithmetic ops update N=res[MSB], Z=(res==0), C=carry out, V=signed overflow; logical/shift ops update N,Z only, C,V held; MOV/LHI/LLI never change flags.
REQ-023 ADC/SBC use flag C as registered at start of EX cycle; back-to-back flag chains need no stall.
REQ-024 Operand forwarding at ISSUE: if a read address equals rd of an EX instruction that writes and fires this cycle, use EX result; else if equal to ext_wr_addr with ext_wr_en, use ext_wr_data; else RF.
REQ-025 ext write occurs at any edge with ext_wr_en; same-edge same-address conflict with EX writeback: EX writeback wins.
REQ-026 res, res_valid update at ex_fire; res_valid clears on res_ready without ex_fire.
REQ-027 No combinational path from res_ready to res or flags.

Reset
REQ-028 CLR at an edge: all registers R[0..NREGS-1] = 0, N=Z=C=V=0, res=0, res_valid=0, EX emptied; in_ready=1 the following cycle.
REQ-029 CLR mid-operation discards the EX instruction with no writeback and no flag update; ext write on a CLR edge is discarded.

Verification
REQ-030 LLI r1,0x34; LHI r1,0x12 back-to-back -> R1 = 0x1234, second uses forwarded low byte.
REQ-031 r2=0xFFFF, r3=0x0001, ADD r4 set_flags -> r4=0x0000, Z=1, C=1, V=0, N=0; then ADC r5=r3+r3 -> 0x0003.
REQ-032 r2=0x7FFF, ADD imm 1 set_flags -> 0x8000, N=1, V=1, C=0; CMP r2,r2 -> Z=1, C=1, no write.
REQ-033 res_ready=0 for 3 cycles with 3 instructions offered -> in_ready low after second accepted, no RF change from stalled op until res_ready=1; then results in order.
REQ-034 ext_wr_en to r6=0xAAAA same edge as EX writes r6=0x5555 -> R6=0x5555; different address -> both written.
REQ-035 CLR asserted while EX holds ADD r7 -> R7=0, flags 0, res_valid=0 after edge.
